// File: rtl/pads_cfg_master.sv
// Wishbone master that walks a latched pad mask and writes one OEN word per selected pad.
// Outputs are registered from next-state values; each access waits for ack or a bounded timeout.
module pads_cfg_master #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_6000,
  parameter int unsigned NUM_PADS  = 44,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                start,
  input  logic [NUM_PADS-1:0] cfg_mask,
  input  logic [NUM_PADS-1:0] cfg_oen,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [3:0]          wbm_sel_o,
  output logic [31:0]         wbm_adr_o,
  output logic [31:0]         wbm_dat_o,
  input  logic                wbm_ack_i,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned IdxW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_PADS - 1);
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StScan, StReq, StDone, StErr} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_PADS-1:0] mask_q, mask_d;
  logic [NUM_PADS-1:0] oen_q, oen_d;
  logic                cyc_q, cyc_d;
  logic [31:0]         adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    oen_d   = oen_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mask_d  = cfg_mask;
          oen_d   = cfg_oen;
          idx_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (mask_q[idx_q]) begin
          cnt_d   = '0;
          state_d = StReq;
        end else if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StReq: begin
        // Ack takes priority over a coincident timeout.
        if (wbm_ack_i) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StScan;
          end
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output registers are loaded from the next state so they line up with the state register.
  always_comb begin
    cyc_d  = (state_d == StReq);
    adr_d  = cyc_d ? (BASE_ADDR + 32'(idx_d)) : 32'd0;
    dat_d  = cyc_d ? {31'd0, oen_d[idx_d]} : 32'd0;
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    err_d  = (state_d == StErr);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      oen_q   <= '0;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      oen_q   <= oen_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = cyc_q;
  assign wbm_sel_o = {4{cyc_q}};
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/pads_cfg_master.md
PADS_CFG_MASTER -- requirements
Module: pads_cfg_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_6000: base byte address of the pad-configuration window.
REQ-002 Parameter NUM_PADS, default 44: number of pad OEN entries, indexed 0..NUM_PADS-1.
REQ-003 Parameter TIMEOUT, default 16: cycles with stb high and no ack before abort; legal range 1..255.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 resetb  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to begin a configuration pass.
REQ-007 cfg_mask  in  NUM_PADS  per-pad write enable; 1 = write this pad.
REQ-008 cfg_oen  in  NUM_PADS  per-pad OEN value to write; 1 = input, 0 = output.
REQ-009 wbm_cyc_o  out  1  Wishbone cycle.
REQ-010 wbm_stb_o  out  1  Wishbone strobe.
REQ-011 wbm_we_o  out  1  Wishbone write enable.
REQ-012 wbm_sel_o  out  4  byte select.
REQ-013 wbm_adr_o  out  32  byte address.
REQ-014 wbm_dat_o  out  32  write data.
REQ-015 wbm_ack_i  in  1  Wishbone acknowledge from the pad-config responder.
REQ-016 busy  out  1  high whenever the state is not IDLE.
REQ-017 done  out  1  one-cycle pulse when a pass completes normally.
REQ-018 err  out  1  one-cycle pulse when a pass aborts on timeout.

Function
REQ-019 States are IDLE, SCAN, REQ, DONE and ERR; all outputs are registered.
REQ-020 In IDLE, start=1 latches cfg_mask and cfg_oen, sets idx=0 and enters SCAN on the next cycle.
REQ-021 start is ignored in every state except IDLE.
REQ-022 Latched mask and OEN values are held for the whole pass and are not affected by later input changes.
REQ-023 SCAN takes one cycle per index; if mask[idx]=1, go to REQ, else increment idx.
REQ-024 In SCAN, a skip at idx=NUM_PADS-1 goes to DONE instead of incrementing.
REQ-025 In REQ, cyc=stb=we=1, sel=4'hF, adr=BASE_ADDR+idx and dat={31'b0, oen[idx]}; all are held stable until ack or timeout.
REQ-026 wbm_ack_i is sampled only in REQ.
REQ-027 On ack in REQ, cyc/stb/we drop the next cycle, then the block goes to SCAN with idx+1, or to DONE if idx=NUM_PADS-1.
REQ-028 Each accepted ack produces exactly one write; no back-to-back strobes are issued without a SCAN cycle between them.
REQ-029 A timeout counter clears on REQ entry and increments each REQ cycle without ack.
REQ-030 When the timeout counter reaches TIMEOUT, the block goes to ERR: cyc/stb/we drop and err=1 for one cycle, then IDLE.
REQ-031 An ERR pass does not assert done.
REQ-032 If ack and counter==TIMEOUT occur in the same cycle, ack wins and the access completes normally.
REQ-033 DONE asserts done=1 for one cycle and returns to IDLE; start in the DONE cycle is ignored.
REQ-034 With an all-zero mask, no Wishbone cycle is issued and done is high exactly NUM_PADS+1 cycles after the start cycle.
REQ-035 wbm_adr_o arithmetic is 32-bit modulo 2^32, and idx uses ceil(log2(NUM_PADS)) bits.
REQ-036 When cyc is low: stb=0, we=0, sel=0, adr=0, dat=0.

Reset
REQ-037 resetb=0 forces, asynchronously, state=IDLE and idx=0, clears the timeout counter and latched mask/OEN, and drives every output to 0.
REQ-038 Reset during REQ drops cyc/stb immediately, aborts the pass, and produces no done or err.
REQ-039 After resetb rises, the block accepts start from the first clk edge.

Verification
REQ-040 mask bits 0 and 43 set, oen[0]=1, oen[43]=0, ack 2 cycles after stb -> two writes (0x3000_6000/0x1, 0x3000_602B/0x0), sel=F, one done pulse.
REQ-041 mask=0, start at cycle 0 -> cyc never high, done=1 at cycle 45, busy high for cycles 1..45.
REQ-042 mask bit 5 set, ack never returned -> stb held 16 cycles at 0x3000_6005, err pulse, busy low next cycle, no done.
REQ-043 ack exactly on the 16th REQ cycle -> normal completion, err stays 0.
REQ-044 start pulsed mid-pass and in the DONE cycle -> ignored; a start after idle runs a full second pass.
REQ-045 resetb low while stb high -> cyc/stb/busy go to 0 before the next clk edge, and neither done nor err pulses.
